ast_packet_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares one ast_width_extender input among SRC_NUM Avalon-ST sources.
- Once a source is granted, it owns the output until its endofpacket beat is accepted, so packets are never interleaved.
- Output stage is registered and drives ast_width_extender's *_i ports directly.
- Each source keeps its own channel value; ast_grant_o reports the owning source.

---
 rtl/ast_packet_arbiter_pkg.sv | 17 +
 rtl/ast_packet_arbiter_rr_arbiter.sv | 36 +++
 rtl/ast_packet_arbiter.sv | 135 +++++++++++++
 tb/tb_ast_packet_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ast_packet_arbiter_pkg.sv
// Shared widths, arbiter sizing and FSM state type for the
// Avalon-ST packet arbiter and the width extender it feeds.
package usr_types_and_params;

    localparam int DATA_IN_W  = 64;
    localparam int EMPTY_IN_W = 3;
    localparam int CHANNEL_W  = 10;

    localparam int SRC_NUM = 4;
    localparam int SRC_W   = $clog2(SRC_NUM);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ast_packet_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after
// last_i, wrapping at N-1 back to 0.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] grant_o,
    output logic         any_o
);

    int         idx;
    logic [W-1:0] idx_w;

    // Walk from the lowest priority down so the nearest
    // requester after last_i is the final one written.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(last_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = W'(idx);
            if (req_i[idx_w]) begin
                grant_o = idx_w;
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ast_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered
// Avalon-ST output among SRC_NUM sources.
module ast_packet_arbiter
    import usr_types_and_params::*;
#(
    parameter int SRC_NUM   = usr_types_and_params::SRC_NUM,
    parameter int DATA_W    = usr_types_and_params::DATA_IN_W,
    parameter int EMPTY_W   = usr_types_and_params::EMPTY_IN_W,
    parameter int CHANNEL_W = usr_types_and_params::CHANNEL_W,
    parameter int SRC_W     = $clog2(SRC_NUM)
) (
    input  logic                              clk_i,
    input  logic                              srst_i,
    input  logic [SRC_NUM-1:0][DATA_W-1:0]    ast_data_i,
    input  logic [SRC_NUM-1:0]                ast_startofpacket_i,
    input  logic [SRC_NUM-1:0]                ast_endofpacket_i,
    input  logic [SRC_NUM-1:0]                ast_valid_i,
    input  logic [SRC_NUM-1:0][EMPTY_W-1:0]   ast_empty_i,
    input  logic [SRC_NUM-1:0][CHANNEL_W-1:0] ast_channel_i,
    output logic [SRC_NUM-1:0]                ast_ready_o,
    output logic [DATA_W-1:0]                 ast_data_o,
    output logic                              ast_startofpacket_o,
    output logic                              ast_endofpacket_o,
    output logic                              ast_valid_o,
    output logic [EMPTY_W-1:0]                ast_empty_o,
    output logic [CHANNEL_W-1:0]              ast_channel_o,
    input  logic                              ast_ready_i,
    output logic [SRC_W-1:0]                  ast_grant_o,
    output logic                              ast_busy_o
);

    arb_state_e state_q, state_d;

    logic [SRC_W-1:0]     grant_q, grant_d;
    logic [SRC_W-1:0]     last_q, last_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 sop_q, sop_d;
    logic                 eop_q, eop_d;
    logic                 valid_q, valid_d;
    logic [EMPTY_W-1:0]   empty_q, empty_d;
    logic [CHANNEL_W-1:0] channel_q, channel_d;

    logic [SRC_W-1:0] pick;
    logic             any_req;
    logic             take;
    logic             acc;

    rr_arbiter #(
        .N (SRC_NUM),
        .W (SRC_W)
    ) u_rr (
        .req_i   (ast_valid_i),
        .last_i  (last_q),
        .grant_o (pick),
        .any_o   (any_req)
    );

    always_comb begin
        take = (state_q == PKT) && (!valid_q || ast_ready_i);
        ast_ready_o = '0;
        ast_ready_o[grant_q] = take;
        acc = take && ast_valid_i[grant_q];

        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        data_d    = data_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        valid_d   = valid_q;
        empty_d   = empty_q;
        channel_d = channel_q;

        if (acc) begin
            data_d    = ast_data_i[grant_q];
            sop_d     = ast_startofpacket_i[grant_q];
            eop_d     = ast_endofpacket_i[grant_q];
            empty_d   = ast_empty_i[grant_q];
            channel_d = ast_channel_i[grant_q];
            valid_d   = 1'b1;
        end else if (ast_ready_i) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = PKT;
                    grant_d = pick;
                    last_d  = pick;
                end
            end
            PKT: begin
                if (acc && ast_endofpacket_i[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= SRC_W'(SRC_NUM - 1);
            data_q    <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            valid_q   <= 1'b0;
            empty_q   <= '0;
            channel_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            data_q    <= data_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            valid_q   <= valid_d;
            empty_q   <= empty_d;
            channel_q <= channel_d;
        end
    end

    assign ast_data_o          = data_q;
    assign ast_startofpacket_o = sop_q;
    assign ast_endofpacket_o   = eop_q;
    assign ast_valid_o         = valid_q;
    assign ast_empty_o         = empty_q;
    assign ast_channel_o       = channel_q;
    assign ast_grant_o         = grant_q;
    assign ast_busy_o          = (state_q == PKT);

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Bench for ast_packet_arbiter: packet-level round-robin model
// with directed and randomized traffic.
module tb_ast_packet_arbiter;
    import usr_types_and_params::*;

    localparam int N  = usr_types_and_params::SRC_NUM;
    localparam int DW = DATA_IN_W;
    localparam int EW = EMPTY_IN_W;
    localparam int CW = usr_types_and_params::CHANNEL_W;
    localparam int GW = $clog2(N);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic [CW-1:0] chan;
    } beat_t;

    logic clk = 1'b0;
    logic srst;
    logic [N-1:0][DW-1:0] d_i;
    logic [N-1:0]         sop_i, eop_i, v_i;
    logic [N-1:0][EW-1:0] e_i;
    logic [N-1:0][CW-1:0] c_i;
    logic [N-1:0]         rdy_o;
    logic [DW-1:0]        d_o;
    logic                 sop_o, eop_o, v_o;
    logic [EW-1:0]        e_o;
    logic [CW-1:0]        c_o;
    logic                 rdy_i;
    logic [GW-1:0]        grant_o;
    logic                 busy_o;

    always #5 clk = ~clk;

    ast_packet_arbiter #(
        .SRC_NUM (N), .DATA_W (DW), .EMPTY_W (EW),
        .CHANNEL_W (CW), .SRC_W (GW)
    ) dut (
        .clk_i (clk), .srst_i (srst),
        .ast_data_i (d_i), .ast_startofpacket_i (sop_i),
        .ast_endofpacket_i (eop_i), .ast_valid_i (v_i),
        .ast_empty_i (e_i), .ast_channel_i (c_i),
        .ast_ready_o (rdy_o), .ast_data_o (d_o),
        .ast_startofpacket_o (sop_o), .ast_endofpacket_o (eop_o),
        .ast_valid_o (v_o), .ast_empty_o (e_o),
        .ast_channel_o (c_o), .ast_ready_i (rdy_i),
        .ast_grant_o (grant_o), .ast_busy_o (busy_o)
    );

    beat_t ob;
    always_comb ob = {d_o, sop_o, eop_o, e_o, c_o};

    beat_t src_q[N][$];
    int    plen[N][$];
    beat_t exp_q[$];
    int    exp_src[$];

    int errors = 0, checks = 0;
    int m_last = N - 1;
    int cyc_n = 0, first_out = -1, last_out = -1, n_out = 0;
    int rmode = 0, vld_pct = 100, stall_left = 0, acc_total = 0;
    logic [N-1:0] acc_mask = '0;
    logic  lat_pend = 1'b0, hold_pend = 1'b0;
    beat_t lat_beat, hold_beat;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_beat(int s, logic [DW-1:0] d, logic sp,
                            logic ep, logic [EW-1:0] em,
                            logic [CW-1:0] ch);
        beat_t b;
        b = '{data: d, sop: sp, eop: ep, empty: em, chan: ch};
        src_q[s].push_back(b);
    endtask

    task automatic add_pkt(int s, int len);
        logic [CW-1:0] ch;
        ch = CW'($urandom());
        for (int i = 0; i < len; i++) begin
            add_beat(s, {$urandom(), $urandom()}, i == 0,
                     i == len - 1,
                     (i == len - 1) ? EW'($urandom()) : '0, ch);
        end
        plen[s].push_back(len);
    endtask

    // Packet-level round robin over the queued packets.
    task automatic plan();
        int off[N];
        int s, len;
        bit found;
        for (int i = 0; i < N; i++) off[i] = 0;
        forever begin
            found = 0;
            s = 0;
            for (int k = 1; k <= N && !found; k++) begin
                s = (m_last + k) % N;
                if (plen[s].size() > 0) found = 1;
            end
            if (!found) break;
            len = plen[s].pop_front();
            for (int i = 0; i < len; i++) begin
                exp_q.push_back(src_q[s][off[s] + i]);
                exp_src.push_back(s);
            end
            off[s] += len;
            m_last = s;
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int s = 0; s < N; s++) begin
            if (src_q[s].size() > 0) begin
                b = src_q[s][0];
                v_i[s] = b.sop ? 1'b1 : ($urandom_range(99) < vld_pct);
                d_i[s] = b.data;
                sop_i[s] = b.sop;
                eop_i[s] = b.eop;
                e_i[s] = b.empty;
                c_i[s] = b.chan;
            end else begin
                v_i[s] = 1'b0;
                d_i[s] = '0;
                sop_i[s] = 1'b0;
                eop_i[s] = 1'b0;
                e_i[s] = '0;
                c_i[s] = '0;
            end
        end
        case (rmode)
            1: rdy_i = ($urandom_range(99) < 70);
            2: begin
                if (n_out == 1 && stall_left > 0) begin
                    rdy_i = 1'b0;
                    stall_left--;
                end else begin
                    rdy_i = 1'b1;
                end
            end
            default: rdy_i = 1'b1;
        endcase
    endtask

    task automatic monitor();
        logic [N-1:0] acc;
        int s, es;
        beat_t e;
        if (lat_pend) begin
            chk("lat_valid", v_o, 1);
            chk("lat_beat", ob, lat_beat);
        end
        if (hold_pend) chk("hold_beat", ob, hold_beat);
        lat_pend = 1'b0;
        hold_pend = 1'b0;
        acc = srst ? '0 : (v_i & rdy_o);
        acc_mask = acc;
        if (acc != '0) begin
            s = 0;
            for (int i = N - 1; i >= 0; i--) if (acc[i]) s = i;
            es = -1;
            if (exp_src.size() > 0) es = exp_src.pop_front();
            chk("acc_onehot", $onehot(acc), 1);
            chk("acc_src", s, es);
            chk("grant", grant_o, es);
            lat_pend = 1'b1;
            lat_beat = src_q[s][0];
        end
        if (v_o && rdy_i) begin
            e = '0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_beat", ob, e);
            end else begin
                chk("out_extra", 1, 0);
            end
            n_out++;
            if (first_out < 0) first_out = cyc_n;
            last_out = cyc_n;
        end else if (v_o) begin
            chk("hold_ready", rdy_o, 0);
            hold_pend = 1'b1;
            hold_beat = ob;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc_n++;
        for (int s = 0; s < N; s++) begin
            if (acc_mask[s]) begin
                void'(src_q[s].pop_front());
                acc_total++;
            end
        end
        drive();
    endtask

    function automatic bit pending();
        bit p;
        p = (exp_q.size() != 0) || v_o;
        for (int s = 0; s < N; s++) p |= (src_q[s].size() != 0);
        return p;
    endfunction

    task automatic run_done(int maxc);
        int k;
        k = 0;
        while (pending() && k < maxc) begin
            cyc();
            k++;
        end
        if (k >= maxc) chk("timeout", 0, 1);
    endtask

    task automatic phase_start();
        first_out = -1;
        last_out = -1;
        n_out = 0;
    endtask

    initial begin
        srst = 1'b1;
        rdy_i = 1'b1;
        v_i = '0; d_i = '0; sop_i = '0; eop_i = '0;
        e_i = '0; c_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", v_o, 0);
        chk("rst_beat", ob, 0);
        chk("rst_ready", rdy_o, 0);
        chk("rst_busy", busy_o, 0);

        // Reset with all sources requesting, then fairness.
        phase_start();
        for (int s = 0; s < N; s++) add_pkt(s, 1);
        plan();
        drive();
        cyc();
        chk("rst2_valid", v_o, 0);
        chk("rst2_ready", rdy_o, 0);
        chk("rst2_beat", ob, 0);
        srst = 1'b0;
        chk("idle_ready", rdy_o, 0);
        cyc();
        chk("first_grant", grant_o, 0);
        chk("first_busy", busy_o, 1);
        run_done(200);
        chk("fair_n", n_out, N);
        chk("fair_span", last_out - first_out, 2 * (N - 1));

        // Contention between sources 0 and 2.
        phase_start();
        add_pkt(0, 4);
        add_pkt(2, 4);
        plan();
        drive();
        run_done(200);
        chk("cont_n", n_out, 8);
        chk("cont_span", last_out - first_out, 8);

        // Single source, fixed contents.
        phase_start();
        add_beat(1, 64'h11, 1'b1, 1'b0, 3'd0, 10'd7);
        add_beat(1, 64'h22, 1'b0, 1'b0, 3'd0, 10'd7);
        add_beat(1, 64'h33, 1'b0, 1'b1, 3'd5, 10'd7);
        plen[1].push_back(3);
        plan();
        drive();
        run_done(200);
        chk("single_n", n_out, 3);
        chk("single_span", last_out - first_out, 2);

        // Backpressure on beat 2 for 5 cycles.
        phase_start();
        rmode = 2;
        stall_left = 5;
        add_pkt(0, 4);
        plan();
        drive();
        run_done(200);
        chk("bp_n", n_out, 4);
        chk("bp_span", last_out - first_out, 8);

        // Randomized traffic, gaps and backpressure.
        rmode = 1;
        vld_pct = 70;
        for (int r = 0; r < 25; r++) begin
            for (int s = 0; s < N; s++) begin
                int cnt;
                cnt = $urandom_range(2);
                for (int p = 0; p < cnt; p++) add_pkt(s, $urandom_range(1, 5));
            end
            plan();
            drive();
            run_done(3000);
        end

        // Reset on beat 2 of a packet from source 3.
        rmode = 0;
        vld_pct = 100;
        acc_total = 0;
        add_pkt(3, 4);
        plan();
        drive();
        for (int k = 0; k < 20 && acc_total < 2; k++) cyc();
        chk("mid_acc", acc_total, 2);
        srst = 1'b1;
        cyc();
        chk("mid_valid", v_o, 0);
        chk("mid_busy", busy_o, 0);
        chk("mid_ready", rdy_o, 0);
        srst = 1'b0;
        src_q[3].delete();
        exp_q.delete();
        exp_src.delete();
        lat_pend = 1'b0;
        hold_pend = 1'b0;
        m_last = N - 1;
        phase_start();
        add_pkt(3, 2);
        plan();
        drive();
        run_done(200);
        chk("regrant_n", n_out, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
